// File: rtl/pair_compute_engine_if.sv
// Operand load port, start/status handshake and result-memory write port
// of the pair compute engine, grouped for connection as a single bundle.
interface pair_compute_engine_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       start;
    logic       busy;
    logic       done;
    logic       res_we;
    logic [1:0] res_addr;
    logic [7:0] res_data;

    // Driver side: supplies operands and start, observes status and results.
    modport master (
        output in_valid, in_data, start,
        input  in_ready, busy, done, res_we, res_addr, res_data
    );

    // Engine side.
    modport slave (
        input  in_valid, in_data, start,
        output in_ready, busy, done, res_we, res_addr, res_data
    );
endinterface

// File: rtl/pair_compute_engine.sv
// Pair compute engine: buffers eight operand bytes, then on start walks
// them in pairs and writes |a-b| style results (difference when a >= b,
// otherwise the 8-bit sum) to a 4-entry result memory, one strobe per pair.
module pair_compute_engine (
    input  logic                  clk,
    input  logic                  reset,
    pair_compute_engine_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] opbuf [0:7];
    logic [3:0] wcnt;
    logic [1:0] k;
    logic [7:0] r1, r2;
    logic       load_fire;
    logic       start_ok;
    logic [7:0] diff, sum;

    // A byte is taken only in IDLE while the buffer has room; start is only
    // honoured once all eight bytes are already in (not on the 8th byte's edge).
    assign load_fire = (state == IDLE) && bus.in_valid && (wcnt < 4'd8);
    assign start_ok  = (state == IDLE) && bus.start && (wcnt == 4'd8);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode; each pair costs RD1, RD2, WR.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = RD1;
            RD1:     state_nx = RD2;
            RD2:     state_nx = WR;
            WR:      state_nx = (k == 2'd3) ? DONE : RD1;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand buffer; contents survive reset and are simply overwritten.
    always_ff @(posedge clk) begin
        if (load_fire) opbuf[wcnt[2:0]] <= bus.in_data;
    end

    // Fill count, pair index and operand registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt <= 4'd0;
            k    <= 2'd0;
            r1   <= 8'd0;
            r2   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_fire) wcnt <= wcnt + 4'd1;
                    if (start_ok)  k    <= 2'd0;
                end
                RD1:  r1 <= opbuf[{k, 1'b0}];
                RD2:  r2 <= opbuf[{k, 1'b1}];
                WR:   if (k != 2'd3) k <= k + 2'd1;
                DONE: begin
                    wcnt <= 4'd0;
                    k    <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    // Modulo-256 arithmetic; carry and borrow simply drop off.
    assign diff = r1 - r2;
    assign sum  = r1 + r2;

    // Moore outputs: decoded from state and registers only.
    assign bus.in_ready = (state == IDLE) && (wcnt < 4'd8);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.res_we   = (state == WR);
    assign bus.res_addr = (state == WR) ? k : 2'd0;
    assign bus.res_data = (state != WR) ? 8'd0 : ((r1 >= r2) ? diff : sum);

endmodule

// File: tb/tb_pair_compute_engine.sv
// Directed bench for pair_compute_engine: hand-computed pair results,
// cycle-exact strobe timing, reset, backpressure and start-filtering cases.
module tb_pair_compute_engine;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    pair_compute_engine_if pif ();

    pair_compute_engine u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the first n bytes of v, one per cycle.
    task automatic load8(input logic [7:0] v [0:7], input int n);
        for (int i = 0; i < n; i++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = v[i];
            @(negedge clk);
        end
        pif.in_valid = 1'b0;
    endtask

    // Pulse start on a full buffer and check cycles 1..14 after the start edge.
    // With poke set, start is also raised while busy (and in DONE), which
    // must have no effect.
    task automatic run_batch(input string nm, input logic [7:0] e [0:3], input bit poke);
        logic we_x;
        pif.start = 1'b1;
        @(negedge clk);
        pif.start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            we_x = (c % 3 == 0) && (c <= 12);
            n_cmp++;
            if (pif.res_we !== we_x) begin
                n_bad++;
                $display("FAIL %s cyc%0d res_we got %b want %b", nm, c, pif.res_we, we_x);
            end
            if (we_x) begin
                n_cmp++;
                if (pif.res_addr !== 2'(c / 3 - 1)) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d res_addr got %0d want %0d", nm, c, pif.res_addr, c / 3 - 1);
                end
                n_cmp++;
                if (pif.res_data !== e[c / 3 - 1]) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d res_data got %0d want %0d", nm, c, pif.res_data, e[c / 3 - 1]);
                end
            end
            n_cmp++;
            if (pif.done !== (c == 13)) begin
                n_bad++;
                $display("FAIL %s cyc%0d done got %b want %b", nm, c, pif.done, c == 13);
            end
            n_cmp++;
            if (pif.busy !== (c <= 13)) begin
                n_bad++;
                $display("FAIL %s cyc%0d busy got %b want %b", nm, c, pif.busy, c <= 13);
            end
            if (c == 14) begin
                n_cmp++;
                if (pif.in_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s cyc14 in_ready got %b want 1", nm, pif.in_ready);
                end
            end
            if (c < 14) begin
                pif.start = poke && (c == 2 || c == 8 || c == 13);
                @(negedge clk);
            end
        end
        pif.start = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] v [0:7];
        v = '{8'd10, 8'd3, 8'd4, 8'd9, 8'd200, 8'd100, 8'd255, 8'd1};
        @(negedge clk);
        n_cmp += 6;
        if (pif.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst in_ready got %b want 1", pif.in_ready); end
        if (pif.busy !== 1'b0)     begin n_bad++; $display("FAIL rst busy got %b want 0", pif.busy); end
        if (pif.done !== 1'b0)     begin n_bad++; $display("FAIL rst done got %b want 0", pif.done); end
        if (pif.res_we !== 1'b0)   begin n_bad++; $display("FAIL rst res_we got %b want 0", pif.res_we); end
        if (pif.res_addr !== 2'd0) begin n_bad++; $display("FAIL rst res_addr got %0d want 0", pif.res_addr); end
        if (pif.res_data !== 8'd0) begin n_bad++; $display("FAIL rst res_data got %0d want 0", pif.res_data); end
        reset = 1'b1;
        @(negedge clk);
        load8(v, 3);
        reset = 1'b0;
        #1;
        n_cmp += 2;
        if (pif.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_load in_ready got %b want 1", pif.in_ready); end
        if (pif.busy !== 1'b0)     begin n_bad++; $display("FAIL rst_load busy got %b want 0", pif.busy); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        // Only 7 bytes since reset: start must be ignored.
        load8(v, 7);
        pif.start = 1'b1;
        @(negedge clk);
        pif.start = 1'b0;
        n_cmp += 2;
        if (pif.busy !== 1'b0)     begin n_bad++; $display("FAIL start7 busy got %b want 0", pif.busy); end
        if (pif.in_ready !== 1'b1) begin n_bad++; $display("FAIL start7 in_ready got %b want 1", pif.in_ready); end
        @(negedge clk);
        n_cmp++;
        if (pif.busy !== 1'b0) begin n_bad++; $display("FAIL start7b busy got %b want 0", pif.busy); end
        pif.in_valid = 1'b1;
        pif.in_data  = v[7];
        @(negedge clk);
        pif.in_valid = 1'b0;
        n_cmp++;
        if (pif.in_ready !== 1'b0) begin n_bad++; $display("FAIL full in_ready got %b want 0", pif.in_ready); end
    endtask

    task automatic test_basic_batch;
        logic [7:0] e [0:3];
        e = '{8'd7, 8'd13, 8'd100, 8'd254};
        run_batch("basic", e, 1'b0);
    endtask

    task automatic test_arith;
        logic [7:0] v [0:7];
        logic [7:0] e [0:3];
        v = '{8'd5, 8'd5, 8'd0, 8'd255, 8'd200, 8'd201, 8'd0, 8'd0};
        e = '{8'd0, 8'd255, 8'd145, 8'd0};
        load8(v, 8);
        run_batch("arith", e, 1'b0);
    endtask

    task automatic test_backpressure;
        logic [7:0] v [0:9];
        logic [7:0] e [0:3];
        v = '{8'd20, 8'd7, 8'd3, 8'd50, 8'd90, 8'd90, 8'd1, 8'd2, 8'd111, 8'd222};
        e = '{8'd13, 8'd53, 8'd0, 8'd3};
        for (int i = 0; i < 10; i++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = v[i];
            @(negedge clk);
            n_cmp++;
            if (pif.in_ready !== (i < 7)) begin
                n_bad++;
                $display("FAIL bp byte%0d in_ready got %b want %b", i, pif.in_ready, i < 7);
            end
        end
        pif.in_valid = 1'b0;
        run_batch("bp", e, 1'b0);
    endtask

    task automatic test_early_start;
        logic [7:0] v [0:7];
        logic [7:0] e [0:3];
        v = '{8'd9, 8'd4, 8'd4, 8'd9, 8'd128, 8'd128, 8'd60, 8'd70};
        e = '{8'd5, 8'd13, 8'd0, 8'd130};
        load8(v, 7);
        pif.in_valid = 1'b1;
        pif.in_data  = v[7];
        pif.start    = 1'b1;
        @(negedge clk);
        pif.in_valid = 1'b0;
        pif.start    = 1'b0;
        n_cmp += 2;
        if (pif.busy !== 1'b0)     begin n_bad++; $display("FAIL early busy got %b want 0", pif.busy); end
        if (pif.in_ready !== 1'b0) begin n_bad++; $display("FAIL early in_ready got %b want 0", pif.in_ready); end
        @(negedge clk);
        n_cmp++;
        if (pif.busy !== 1'b0) begin n_bad++; $display("FAIL early2 busy got %b want 0", pif.busy); end
        run_batch("early", e, 1'b0);
    endtask

    task automatic test_reset_mid;
        logic [7:0] v [0:7];
        v = '{8'd3, 8'd1, 8'd9, 8'd9, 8'd2, 8'd250, 8'd77, 8'd0};
        load8(v, 8);
        pif.start = 1'b1;
        @(negedge clk);
        pif.start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp += 2;
        if (pif.res_we !== 1'b1)   begin n_bad++; $display("FAIL mid wr1 res_we got %b want 1", pif.res_we); end
        if (pif.res_addr !== 2'd1) begin n_bad++; $display("FAIL mid wr1 res_addr got %0d want 1", pif.res_addr); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp += 3;
        if (pif.busy !== 1'b0)     begin n_bad++; $display("FAIL mid busy got %b want 0", pif.busy); end
        if (pif.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid in_ready got %b want 1", pif.in_ready); end
        if (pif.res_we !== 1'b0)   begin n_bad++; $display("FAIL mid res_we got %b want 0", pif.res_we); end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            n_cmp++;
            if (pif.res_we !== 1'b0 || pif.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_after cyc%0d res_we/busy got %b%b want 00", c, pif.res_we, pif.busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [0:7];
        logic [7:0] vb [0:7];
        logic [7:0] ea [0:3];
        logic [7:0] eb [0:3];
        va = '{8'd50, 8'd20, 8'd1, 8'd1, 8'd30, 8'd40, 8'd255, 8'd255};
        ea = '{8'd30, 8'd0, 8'd70, 8'd0};
        vb = '{8'd0, 8'd1, 8'd100, 8'd50, 8'd7, 8'd8, 8'd129, 8'd128};
        eb = '{8'd1, 8'd50, 8'd15, 8'd1};
        load8(va, 8);
        run_batch("b2b_a", ea, 1'b1);
        load8(vb, 8);
        run_batch("b2b_b", eb, 1'b0);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b0;
        pif.in_valid = 1'b0;
        pif.in_data  = 8'd0;
        pif.start    = 1'b0;
        test_reset;
        test_basic_batch;
        test_arith;
        test_backpressure;
        test_early_start;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
